// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             br_next;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    bit_d    = ra[0] ^ rb[0] ^ br;
    br_next  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Minuend register doubles as the result shift register: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ra         <= '0;
      rb         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
`ifdef SUB_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra  <= {bit_d, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            cnt        <= '0;
            diff       <= {bit_d, ra[WIDTH-1:1]};
            borrow_out <= br_next;
`ifdef SUB_OVERFLOW_EN
            // On the final bit ra[0]/rb[0] are the original operand sign bits
            overflow   <= (ra[0] != rb[0]) && (bit_d != ra[0]);
`endif
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
